// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes and FSM states.
package alu_muldiv_pkg;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t;

    // funct3[2] separates the divide/remainder group from the multiplies.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response handshake bundle between the execute stage and the multiply/divide unit.
interface alu_muldiv_if #(parameter int DATA_WIDTH = 32);

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  div_zero;

    modport master (
        output flush, in_valid, op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, div_zero
    );

    modport slave (
        input  flush, in_valid, op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, div_zero
    );

endinterface

// File: rtl/alu_muldiv_div_iter.sv
// One restoring-division step on magnitudes: shift in the next dividend bit, trial-subtract the divisor.
module alu_muldiv_div_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rem,
    input  logic [DATA_WIDTH-1:0] i_quo,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic [DATA_WIDTH-1:0] o_rem,
    output logic [DATA_WIDTH-1:0] o_quo
);

    logic [DATA_WIDTH:0] w_shifted;
    logic [DATA_WIDTH:0] w_diff;

    assign w_shifted = {i_rem, i_quo[DATA_WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, i_divisor};

    // Top bit of the difference is the borrow: set means the divisor did not fit.
    assign o_rem = w_diff[DATA_WIDTH] ? w_shifted[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
    assign o_quo = {i_quo[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Define ALU_MULDIV_FAST_MUL_EN for single-cycle combinational multiplies; divides always iterate.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_muldiv_if.slave   bus
);

    localparam int W  = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;

    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [W2-1:0] cond_neg2(input logic [W2-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    muldiv_state_t   r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_op;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [W-1:0]    r_mcand;
    logic [W2-1:0]   r_prod;
    logic [W-1:0]    r_result;
    logic            r_div_zero;

    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [W-1:0]    w_mag_a;
    logic [W-1:0]    w_mag_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic [W-1:0]    w_special_res;
    logic [W:0]      w_mul_sum;
    logic [W2-1:0]   w_mul_next;
    logic [W2-1:0]   w_mul_fix;
    logic [W-1:0]    w_div_rem;
    logic [W-1:0]    w_div_quo;
    logic [W-1:0]    w_mul_res;
    logic [W-1:0]    w_div_res;
    logic [W-1:0]    w_fin;

    assign w_accept   = (r_state == IDLE) && bus.in_valid && !bus.flush;
    assign w_is_div   = op_is_div(bus.op);
    assign w_a_signed = (bus.op == MULDIV_OP_MULH) || (bus.op == MULDIV_OP_MULHSU) ||
                        (bus.op == MULDIV_OP_DIV)  || (bus.op == MULDIV_OP_REM);
    assign w_b_signed = (bus.op == MULDIV_OP_MULH) || (bus.op == MULDIV_OP_DIV) ||
                        (bus.op == MULDIV_OP_REM);
    assign w_sa       = w_a_signed && bus.op_a[W-1];
    assign w_sb       = w_b_signed && bus.op_b[W-1];
    assign w_mag_a    = cond_neg(bus.op_a, w_sa);
    assign w_mag_b    = cond_neg(bus.op_b, w_sb);
    assign w_b_zero   = (bus.op_b == '0);
    assign w_ovf      = ((bus.op == MULDIV_OP_DIV) || (bus.op == MULDIV_OP_REM)) &&
                        (bus.op_a == {1'b1, {(W-1){1'b0}}}) && (bus.op_b == '1);

    // funct3[1] selects the remainder flavour among the divide ops.
    assign w_special_res = w_b_zero ? (bus.op[1] ? bus.op_a : '1)
                                    : (bus.op[1] ? '0 : bus.op_a);

    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_prod[W2-1:W]} + {1'b0, (r_prod[0] ? r_mcand : '0)};
    assign w_mul_next = {w_mul_sum, r_prod[W-1:1]};

    alu_muldiv_div_iter #(.DATA_WIDTH(W)) u_div_iter (
        .i_rem     (r_prod[W2-1:W]),
        .i_quo     (r_prod[W-1:0]),
        .i_divisor (r_mcand),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    assign w_mul_fix = cond_neg2(w_mul_next, r_neg_q);
    assign w_mul_res = (r_op == MULDIV_OP_MUL) ? w_mul_fix[W-1:0] : w_mul_fix[W2-1:W];
    assign w_div_res = r_op[1] ? cond_neg(w_div_rem, r_neg_r) : cond_neg(w_div_quo, r_neg_q);
    assign w_fin     = (r_state == DIV) ? w_div_res : w_mul_res;

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [W2-1:0] w_fast_prod;
    logic [W-1:0]  w_fast_res;

    assign w_fast_prod = cond_neg2(W2'(w_mag_a) * W2'(w_mag_b), w_sa ^ w_sb);
    assign w_fast_res  = (bus.op == MULDIV_OP_MUL) ? w_fast_prod[W-1:0] : w_fast_prod[W2-1:W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    if (w_is_div && (w_b_zero || w_ovf)) begin
                        r_state    <= DONE;
                        r_result   <= w_special_res;
                        r_div_zero <= w_b_zero;
                    end else if (w_is_div) begin
                        r_state <= DIV;
                        r_cnt   <= CNT_W'(W);
                    end else begin
`ifdef ALU_MULDIV_FAST_MUL_EN
                        r_state    <= DONE;
                        r_result   <= w_fast_res;
                        r_div_zero <= 1'b0;
`else
                        r_state <= MUL;
                        r_cnt   <= CNT_W'(W);
`endif
                    end
                end
                MUL, DIV: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state    <= DONE;
                        r_result   <= w_fin;
                        r_div_zero <= 1'b0;
                    end
                end
                DONE: if (bus.out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operands are held as magnitudes; signs are reapplied only when the result is formed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= bus.op;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_mcand <= w_is_div ? w_mag_b : w_mag_a;
            r_prod  <= {{W{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
        end else if (r_state == MUL) begin
            r_prod <= w_mul_next;
        end else if (r_state == DIV) begin
            r_prod <= {w_div_rem, w_div_quo};
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized self-checking bench for alu_muldiv against a plain-arithmetic RV32M reference model.
module tb_alu_muldiv;

    localparam int W = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_muldiv_if #(.DATA_WIDTH(W)) bus();

    alu_muldiv #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {div_zero, result} from the RV32M rules using 64-bit arithmetic.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return {1'b0, p[31:0]}; end
            3'd1: begin p = sa * sb; return {1'b0, p[63:32]}; end
            3'd2: begin p = sa * ub; return {1'b0, p[63:32]}; end
            3'd3: begin p = ua * ub; return {1'b0, p[63:32]}; end
            3'd4: begin
                if (b == 0) return {1'b1, 32'hFFFF_FFFF};
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return {1'b0, a};
                p = sa / sb; return {1'b0, p[31:0]};
            end
            3'd5: begin
                if (b == 0) return {1'b1, 32'hFFFF_FFFF};
                p = ua / ub; return {1'b0, p[31:0]};
            end
            3'd6: begin
                if (b == 0) return {1'b1, a};
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 33'd0;
                p = sa % sb; return {1'b0, p[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a};
                p = ua % ub; return {1'b0, p[31:0]};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 0) return 1;
            if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
            return W + 1;
        end
`ifdef ALU_MULDIV_FAST_MUL_EN
        return 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 100 && !bus.in_ready; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [32:0] exp;
        int lat;
        exp = model(op, a, b);
        wait_idle();
        bus.op = op; bus.op_a = a; bus.op_b = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("lat op%0d", op), 64'(lat), 64'(exp_lat(op, a, b)));
        check($sformatf("res op%0d %h %h", op, a, b), 64'(bus.result), 64'(exp[31:0]));
        check($sformatf("dz op%0d", op), 64'(bus.div_zero), 64'(exp[32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold valid/ready", {62'b0, bus.out_valid, bus.in_ready}, 64'b10);
            check("hold result", 64'(bus.result), 64'(exp[31:0]));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] a, b;
        int seen;
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = '0; bus.op_a = '0; bus.op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset div_zero", 64'(bus.div_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd1, MIN_NEG, MIN_NEG, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 0);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd6, 32'd5, 32'd0, 0);
        run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, 0);
        run_op(3'd6, MIN_NEG, 32'hFFFF_FFFF, 0);
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5);

        // Flush mid-divide: no result may appear
        wait_idle();
        bus.op = 3'd5; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush idle", {62'b0, bus.in_ready, bus.out_valid}, 64'b10);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("flush no result", 64'(seen), 64'd0);
        run_op(3'd5, 32'd1000, 32'd3, 0);

        // Flush wins over a same-cycle accept
        bus.op = 3'd5; bus.op_a = 32'd5; bus.op_b = 32'd0;
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        @(posedge clk); #1;
        check("flush beats accept", {62'b0, bus.in_ready, bus.out_valid}, 64'b10);

        // Asynchronous reset mid-multiply, with a nonzero result already held
        run_op(3'd5, 32'd5, 32'd0, 0);
        bus.op = 3'd0; bus.op_a = 32'd123; bus.op_b = 32'd456; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst ctrl", {62'b0, bus.in_ready, bus.out_valid}, 64'b10);
        check("async rst result", {31'b0, bus.div_zero, bus.result}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd0, 32'd123, 32'd456, 0);

        // Randomized ops with corner operands and random backpressure
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 4))
                0: a = MIN_NEG;
                1: a = 32'hFFFF_FFFF;
                2: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_op(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
